wb_dram_wr_buffer: RTL and testbench
====================================

WB_DRAM_WR_BUFFER -- requirements
Module: wb_dram_wr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning byte-address width on both sides.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  in  1  system clock (50MHz user clock from the DRAM controller).
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_adr/s_dat_w/s_sel/s_we/s_cyc/s_stb  in  AW/32/4/1/1/1  pipelined Wishbone slave request from CPU/crossbar.
REQ-007 s_dat_r/s_ack/s_err/s_stall  out  32/1/1/1  slave response.
REQ-008 m_adr/m_dat_w/m_sel/m_we/m_cyc/m_stb  out  AW/32/4/1/1/1  pipelined Wishbone master toward DRAM user port (byte address passed unchanged).
REQ-009 m_dat_r/m_ack/m_err/m_stall  in  32/1/1/1  master response.
REQ-010 fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 wr_err  out  1  sticky flag: a posted write received m_err.

Function
REQ-012 Write accept: s_cyc&s_stb&s_we&!s_stall with FIFO not full SHALL push {adr,dat_w,sel} and assert s_ack exactly one cycle later, s_err=0.
REQ-013 s_stall SHALL be 1 when FIFO full (write pending) or when a read is pending and FIFO non-empty or drain FSM not IDLE; otherwise 0; 0 whenever s_cyc=0.
REQ-014 Drain FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
REQ-015 IDLE->WR_REQ when FIFO non-empty (writes have priority); IDLE->RD_REQ when FIFO empty and read request present; read captured on entry.
REQ-016 WR_REQ/RD_REQ: m_cyc=1, m_stb=1, fields from FIFO head / captured read; ->*_WAIT on cycle m_stall=0.
REQ-017 WR_WAIT/RD_WAIT: m_cyc=1, m_stb=0; on m_ack or m_err -> IDLE; FIFO pop in WR_WAIT on that cycle.
REQ-018 Read response: s_dat_r registered from m_dat_r, s_ack (or s_err if m_err) asserted one cycle after master ack; minimum read latency from accept = 3 cycles with zero-wait slave.
REQ-019 Ordering: a read SHALL never be issued while FIFO non-empty (read-after-write coherence).
REQ-020 Write m_err SHALL set wr_err and still pop the entry; no retry.
REQ-021 Simultaneous push and pop SHALL keep fill unchanged; push when full never occurs (stall); no bypass path.
REQ-022 Pointers SHALL wrap modulo DEPTH; fill SHALL never exceed DEPTH.
REQ-023 s_cyc dropped during RD_REQ/RD_WAIT: master transaction SHALL complete, s_ack/s_err suppressed.
REQ-024 s_cyc dropped with FIFO non-empty: buffered writes SHALL still drain.
REQ-025 Only one master transaction outstanding; m_cyc=0 in IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, pointers and fill 0, FIFO contents discarded, wr_err 0, all outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it without completion on either side.

Structure
REQ-028 Package wb_dram_pkg SHALL hold the FIFO entry struct (adr, dat, sel) and the drain-state enum.
REQ-029 FIFO SHALL be a sub-module wb_sync_fifo (parameterised width/depth, push/pop/full/empty/fill).

Verification
REQ-030 Write 0x1000<-0xDEADBEEF, zero-wait slave -> s_ack 1 cycle after accept; m_stb with m_adr=0x1000 next cycle; fill 1->0.
REQ-031 5 back-to-back writes, DEPTH=4, slave m_stall=1 for 20 cycles -> 4 acked, s_stall=1 on 5th until first m_ack; all 5 reach slave in order.
REQ-032 Write 0x2000<-0x12345678 then read 0x2000 -> read m_stb only after write m_ack; s_dat_r=0x12345678.
REQ-033 Slave m_err on posted write -> wr_err=1 and stays 1; next write drains normally.
REQ-034 Drop s_cyc during RD_WAIT -> no s_ack; m_cyc falls after m_ack; FSM returns IDLE.
REQ-035 Assert rst_n=0 in WR_WAIT with fill=3 -> next cycle fill=0, m_cyc=0, wr_err=0.

Source files
------------

// File: rtl/wb_dram_pkg.sv
// wb_dram_pkg: shared types for the DRAM posted-write buffer.
// Holds the buffered write entry layout and the drain FSM encoding.
package wb_dram_pkg;

   localparam int unsigned ADR_W = 32;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [31:0]      dat;
      logic [3:0]       sel;
   } wr_ent_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_WAIT,
      RD_REQ,
      RD_WAIT
   } drain_st_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// wb_sync_fifo: single-clock FIFO with occupancy count.
// Head entry is presented combinationally on dout.
module wb_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [PW:0]  fill
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (fill == FULL_CNT);
   assign empty   = (fill == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers are log2(DEPTH) wide, so wrap is free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            fill <= fill + 1'b1;
         else if (pop_ok && !push_ok)
            fill <= fill - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_dram_wr_buffer.sv
// wb_dram_wr_buffer: posted-write buffer between a pipelined
// Wishbone slave port and the DRAM user port; reads wait for drain.
module wb_dram_wr_buffer
   import wb_dram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   localparam int FW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] s_adr,
   input  logic [31:0]   s_dat_w,
   input  logic [3:0]    s_sel,
   input  logic          s_we,
   input  logic          s_cyc,
   input  logic          s_stb,
   output logic [31:0]   s_dat_r,
   output logic          s_ack,
   output logic          s_err,
   output logic          s_stall,
   output logic [AW-1:0] m_adr,
   output logic [31:0]   m_dat_w,
   output logic [3:0]    m_sel,
   output logic          m_we,
   output logic          m_cyc,
   output logic          m_stb,
   input  logic [31:0]   m_dat_r,
   input  logic          m_ack,
   input  logic          m_err,
   input  logic          m_stall,
   output logic [FW-1:0] fill,
   output logic          wr_err
);

   drain_st_e     st;
   drain_st_e     st_nx;
   wr_ent_t       push_ent;
   wr_ent_t       head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          wr_req;
   logic          rd_req;
   logic          rd_start;
   logic          rd_done;
   logic          m_done;
   logic          rd_abort;
   logic [AW-1:0] rd_adr;
   logic [3:0]    rd_sel;

   assign wr_req  = s_cyc & s_stb & s_we;
   assign rd_req  = s_cyc & s_stb & ~s_we;
   assign s_stall = (wr_req & full)
                  | (rd_req & (~empty | (st != IDLE)));
   assign push    = wr_req & ~s_stall;
   assign m_done  = m_ack | m_err;
   assign pop     = (st == WR_WAIT) & m_done;
   assign rd_start = (st == IDLE) & empty & rd_req;
   // A read whose cycle was dropped still completes on the
   // master side but must not answer the slave side.
   assign rd_done = (st == RD_WAIT) & m_done
                  & s_cyc & ~rd_abort;

   always_comb begin
      push_ent     = '0;
      push_ent.adr = ADR_W'(s_adr);
      push_ent.dat = s_dat_w;
      push_ent.sel = s_sel;
   end

   wb_sync_fifo #(
      .W     ($bits(wr_ent_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .fill  (fill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end

   // Buffered writes always win so reads see them.
   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE: begin
            if (!empty)      st_nx = WR_REQ;
            else if (rd_req) st_nx = RD_REQ;
         end
         WR_REQ:  if (!m_stall) st_nx = WR_WAIT;
         WR_WAIT: if (m_done)   st_nx = IDLE;
         RD_REQ:  if (!m_stall) st_nx = RD_WAIT;
         RD_WAIT: if (m_done)   st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_comb begin
      m_cyc   = 1'b0;
      m_stb   = 1'b0;
      m_we    = 1'b0;
      m_adr   = '0;
      m_dat_w = '0;
      m_sel   = '0;
      unique case (1'b1)
         (st == WR_REQ): begin
            m_cyc   = 1'b1;
            m_stb   = 1'b1;
            m_we    = 1'b1;
            m_adr   = AW'(head.adr);
            m_dat_w = head.dat;
            m_sel   = head.sel;
         end
         (st == WR_WAIT): begin
            m_cyc = 1'b1;
            m_we  = 1'b1;
         end
         (st == RD_REQ): begin
            m_cyc = 1'b1;
            m_stb = 1'b1;
            m_adr = rd_adr;
            m_sel = rd_sel;
         end
         (st == RD_WAIT): m_cyc = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_adr   <= '0;
         rd_sel   <= '0;
         rd_abort <= 1'b0;
         s_ack    <= 1'b0;
         s_err    <= 1'b0;
         s_dat_r  <= '0;
         wr_err   <= 1'b0;
      end else begin
         s_ack <= push | (rd_done & ~m_err);
         s_err <= rd_done & m_err;
         if (rd_start) begin
            rd_adr   <= s_adr;
            rd_sel   <= s_sel;
            rd_abort <= 1'b0;
         end else if (!s_cyc
                  && (st == RD_REQ || st == RD_WAIT)) begin
            rd_abort <= 1'b1;
         end
         if (rd_done)      s_dat_r <= m_dat_r;
         if (pop && m_err) wr_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_dram_wr_buffer.sv
// tb_wb_dram_wr_buffer: vector table plus corner-case sequences
// for the DRAM write buffer, with a posted-write scoreboard.
`timescale 1ns/1ps
module tb_wb_dram_wr_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] s_adr;
   logic [31:0]   s_dat_w;
   logic [3:0]    s_sel;
   logic          s_we;
   logic          s_cyc;
   logic          s_stb;
   logic [31:0]   s_dat_r;
   logic          s_ack;
   logic          s_err;
   logic          s_stall;
   logic [AW-1:0] m_adr;
   logic [31:0]   m_dat_w;
   logic [3:0]    m_sel;
   logic          m_we;
   logic          m_cyc;
   logic          m_stb;
   logic [31:0]   m_dat_r;
   logic          m_ack;
   logic          m_err;
   logic          m_stall;
   logic [FW-1:0] fill;
   logic          wr_err;

   always #5 clk = ~clk;

   wb_dram_wr_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_adr   (s_adr),
      .s_dat_w (s_dat_w),
      .s_sel   (s_sel),
      .s_we    (s_we),
      .s_cyc   (s_cyc),
      .s_stb   (s_stb),
      .s_dat_r (s_dat_r),
      .s_ack   (s_ack),
      .s_err   (s_err),
      .s_stall (s_stall),
      .m_adr   (m_adr),
      .m_dat_w (m_dat_w),
      .m_sel   (m_sel),
      .m_we    (m_we),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_dat_r (m_dat_r),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .m_stall (m_stall),
      .fill    (fill),
      .wr_err  (wr_err)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;

   wr_t exp_q[$];
   wr_t got_q[$];
   int  got_ix = 0;
   int  tot_wr = 0;
   int  rd_snap;

   // DRAM-side slave model: pipelined, optional extra ack delay
   logic        slv_stall  = 1'b0;
   int          stall_left = 0;
   int          slv_dly    = 0;
   bit          slv_err    = 1'b0;
   logic [31:0] smem [64];
   bit          pend;
   bit          perr;
   int          cnt;

   assign m_stall = slv_stall;

   function automatic logic [5:0] sidx(input logic [31:0] a);
      return {a[14:12], a[4:2]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ack   <= 1'b0;
         m_err   <= 1'b0;
         m_dat_r <= '0;
         pend    <= 1'b0;
         perr    <= 1'b0;
         cnt     <= 0;
         for (int k = 0; k < 64; k++) smem[k] <= '0;
      end else begin
         m_ack <= 1'b0;
         m_err <= 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               m_ack <= !perr;
               m_err <= perr;
               pend  <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end else if (m_cyc && m_stb && !m_stall) begin
            if (m_we) begin
               got_q.push_back(wr_t'{adr: m_adr, dat: m_dat_w,
                                     sel: m_sel});
               if (!slv_err)
                  for (int b = 0; b < 4; b++)
                     if (m_sel[b])
                        smem[sidx(m_adr)][8*b +: 8] <= m_dat_w[8*b +: 8];
            end else begin
               rd_snap <= got_q.size();
               m_dat_r <= smem[sidx(m_adr)];
            end
            if (slv_dly == 0) begin
               m_ack <= !slv_err;
               m_err <= slv_err;
            end else begin
               pend <= 1'b1;
               perr <= slv_err;
               cnt  <= slv_dly - 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
         stall_left--;
         if (stall_left == 0) slv_stall = 1'b0;
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sl);
      int n = 0;
      s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
      s_adr = a; s_dat_w = d; s_sel = sl;
      #1;
      while (s_stall && n < 200) begin step(); #1; n++; end
      chk("wr_accept", s_stall, 0);
      if (!s_stall) begin
         step();
         exp_q.push_back(wr_t'{adr: a, dat: d, sel: sl});
         tot_wr++;
         chk("wr_s_ack", s_ack, 1);
         chk("wr_s_err", s_err, 0);
      end
      s_stb = 1'b0; s_we = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] a, input logic [31:0] ed,
                          input bit ee);
      int n = 0;
      s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
      s_adr = a; s_sel = 4'hF;
      #1;
      while (s_stall && n < 200) begin step(); #1; n++; end
      chk("rd_accept", s_stall, 0);
      if (!s_stall) begin
         step();
         s_stb = 1'b0;
         n = 0;
         while (!(s_ack || s_err) && n < 100) begin step(); n++; end
         chk("rd_latency", n, 2);
         chk("rd_after_writes", rd_snap, tot_wr);
         chk("rd_s_err", s_err, ee);
         chk("rd_s_ack", s_ack, !ee);
         if (!ee) chk("rd_data", s_dat_r, ed);
      end
      s_stb = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_cyc || fill != 0) && n < 500) begin step(); n++; end
      chk("drain_idle", (m_cyc || fill != 0), 0);
   endtask

   task automatic sb_check();
      wr_t e;
      wr_t g;
      wait_idle();
      chk("sb_count", got_q.size() - got_ix, exp_q.size());
      while (exp_q.size() > 0 && got_ix < got_q.size()) begin
         e = exp_q.pop_front();
         g = got_q[got_ix];
         got_ix++;
         chk("sb_adr", g.adr, e.adr);
         chk("sb_dat", g.dat, e.dat);
         chk("sb_sel", g.sel, e.sel);
      end
      exp_q.delete();
      got_ix = got_q.size();
   endtask

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      bit          serr;
      bit          settle;
      logic [31:0] exp_dat;
      bit          exp_serr;
      bit          exp_wr_err;
   } vec_t;

   vec_t vt[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      int n;
      bit saw_mack;
      bit cyc_ok;

      vt[0]  = '{1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0, 0};
      vt[1]  = '{0, 32'h1000, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0};
      vt[2]  = '{1, 32'h1004, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0, 0, 0};
      vt[3]  = '{1, 32'h1004, 32'h000000AA, 4'h1, 0, 1, 32'h0, 0, 0};
      vt[4]  = '{0, 32'h1004, 32'h0, 4'hF, 0, 0, 32'hCAFEF0AA, 0, 0};
      vt[5]  = '{0, 32'h3000, 32'h0, 4'hF, 1, 0, 32'h0, 1, 0};
      vt[6]  = '{1, 32'h2000, 32'h12345678, 4'hF, 0, 0, 32'h0, 0, 0};
      vt[7]  = '{0, 32'h2000, 32'h0, 4'hF, 0, 0, 32'h12345678, 0, 0};
      vt[8]  = '{1, 32'h4000, 32'h0BADF00D, 4'hF, 1, 1, 32'h0, 0, 1};
      vt[9]  = '{1, 32'h4004, 32'h11112222, 4'hF, 0, 1, 32'h0, 0, 1};
      vt[10] = '{0, 32'h4004, 32'h0, 4'hF, 0, 0, 32'h11112222, 0, 0};
      vt[11] = '{0, 32'h4000, 32'h0, 4'hF, 0, 0, 32'h00000000, 0, 0};

      rst_n = 1'b0;
      s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
      s_adr = '0; s_dat_w = '0; s_sel = '0;
      step();
      step();
      chk("rst_s_ack", {s_ack, s_err, s_stall}, 0);
      chk("rst_s_dat_r", s_dat_r, 0);
      chk("rst_m_ctrl", {m_cyc, m_stb, m_we}, 0);
      chk("rst_m_adr", m_adr, 0);
      chk("rst_fill", fill, 0);
      chk("rst_wr_err", wr_err, 0);
      rst_n = 1'b1;
      step();

      // single posted write, zero-wait slave
      wb_write(32'h1000, 32'hDEADBEEF, 4'hF);
      chk("w1_fill_1", fill, 1);
      chk("w1_no_stb_yet", m_stb, 0);
      step();
      chk("w1_m_stb", {m_cyc, m_stb, m_we}, 3'b111);
      chk("w1_m_adr", m_adr, 32'h1000);
      chk("w1_m_dat", m_dat_w, 32'hDEADBEEF);
      chk("w1_m_sel", m_sel, 4'hF);
      step();
      chk("w1_wait", {m_cyc, m_stb}, 2'b10);
      step();
      chk("w1_fill_0", fill, 0);
      chk("w1_idle", m_cyc, 0);

      for (int i = 0; i < 12; i++) begin
         slv_err = vt[i].serr;
         if (vt[i].we)
            wb_write(vt[i].adr, vt[i].dat, vt[i].sel);
         else
            wb_read(vt[i].adr, vt[i].exp_dat, vt[i].exp_serr);
         if (vt[i].settle || vt[i].serr) begin
            wait_idle();
            chk($sformatf("v%0d_wr_err", i), wr_err, vt[i].exp_wr_err);
         end
         slv_err = 1'b0;
      end
      sb_check();

      // five back-to-back writes into a stalled slave
      slv_stall  = 1'b1;
      stall_left = 20;
      s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_sel = 4'hF;
      for (int i = 0; i < 5; i++) begin
         n = 0;
         s_adr   = 32'h5000 + 32'(i * 4);
         s_dat_w = 32'hA0000000 + 32'(i);
         #1;
         if (i == 4) begin
            chk("b2b_5th_stalled", s_stall, 1);
            chk("b2b_full_fill", fill, 4);
         end else begin
            chk("b2b_no_stall", s_stall, 0);
         end
         while (s_stall && n < 100) begin step(); #1; n++; end
         if (i == 4)
            chk("b2b_stall_len", (n >= 15 && n <= 20), 1);
         step();
         exp_q.push_back(wr_t'{adr: s_adr, dat: s_dat_w, sel: 4'hF});
         tot_wr++;
         chk("b2b_s_ack", s_ack, 1);
      end
      s_stb = 1'b0; s_we = 1'b0;
      sb_check();

      // drop s_cyc while the read sits in RD_WAIT
      slv_dly = 3;
      s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
      s_adr = 32'h1000; s_sel = 4'hF;
      #1;
      chk("abort_rd_accept", s_stall, 0);
      step();
      s_stb = 1'b0;
      step();
      chk("abort_in_rd_wait", {m_cyc, m_stb}, 2'b10);
      s_cyc = 1'b0;
      acks = 0; saw_mack = 1'b0; cyc_ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_ack || s_err) acks++;
         if (m_ack) begin
            saw_mack = 1'b1;
            if (!m_cyc) cyc_ok = 1'b0;
         end
      end
      chk("abort_no_s_ack", acks, 0);
      chk("abort_saw_m_ack", saw_mack, 1);
      chk("abort_cyc_until_m_ack", cyc_ok, 1);
      chk("abort_idle", m_cyc, 0);
      slv_dly = 0;

      // reset while a write is in WR_WAIT with three buffered
      slv_dly = 30;
      wb_write(32'h6000, 32'h60000000, 4'hF);
      wb_write(32'h6004, 32'h60000004, 4'hF);
      wb_write(32'h6008, 32'h60000008, 4'hF);
      n = 0;
      while (!(m_cyc && !m_stb && fill == 3) && n < 50) begin
         step(); n++;
      end
      chk("pre_rst_wr_wait_fill3", (m_cyc && !m_stb && fill == 3), 1);
      chk("pre_rst_wr_err", wr_err, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_fill", fill, 0);
      chk("rst_async_m_cyc", m_cyc, 0);
      step();
      chk("rst_fill", fill, 0);
      chk("rst_m_cyc", m_cyc, 0);
      chk("rst_wr_err_clr", wr_err, 0);
      rst_n = 1'b1;
      exp_q.delete();
      acks = 0; n = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (s_ack || s_err) acks++;
         if (m_cyc) n++;
      end
      chk("post_rst_no_ack", acks, 0);
      chk("post_rst_no_m_cyc", n, 0);
      slv_dly = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
